// File: rtl/pc_pkg.sv
// Shared encodings for the PC unit: next-PC source select and branch funct3 decode.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JAL  = 2'b10,
    PC_JALR = 2'b11
  } pc_src_e;

  localparam logic [2:0] BT_BEQ  = 3'b000;
  localparam logic [2:0] BT_BNE  = 3'b001;
  localparam logic [2:0] BT_BLT  = 3'b100;
  localparam logic [2:0] BT_BGE  = 3'b101;
  localparam logic [2:0] BT_BLTU = 3'b110;
  localparam logic [2:0] BT_BGEU = 3'b111;

  // funct3 010/011 are not branch encodings and never take.
  function automatic logic branch_cond(input logic [2:0] btype, input logic zero,
                                       input logic lt, input logic ltu);
    logic c;
    case (btype)
      BT_BEQ:  c = zero;
      BT_BNE:  c = ~zero;
      BT_BLT:  c = lt;
      BT_BGE:  c = ~lt;
      BT_BLTU: c = ltu;
      BT_BGEU: c = ~ltu;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack; overflow silently overwrites the oldest entry.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [PW-1:0]   tp_q, tp_d, wr_ptr;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic [XLEN-1:0] mem_q [RAS_DEPTH];

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = tp_q;
    if (push && pop) begin
      // Tail call through a return: replace the top entry in place.
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = CW'(1);
    end else if (push) begin
      wr_en  = 1'b1;
      wr_ptr = tp_q + PW'(1);
      tp_d   = tp_q + PW'(1);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else if (pop && (cnt_q != '0)) begin
      tp_d  = tp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are only meaningful below cnt, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= push_data;
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_MAX);
  assign top   = empty ? '0 : mem_q[tp_q];

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-head PC unit: PC register, next-PC select, return-address stack and
// saturating count of mispredicted returns.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic             branch,
  input  logic [2:0]       btype,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic [XLEN-1:0]  immediate,
  input  logic             jal,
  input  logic             jalr,
  input  logic [XLEN-1:0]  jalr_target,
  input  logic             call,
  input  logic             ret,
  output logic [XLEN-1:0]  pc_current,
  output logic [1:0]       pc_src,
  output logic [XLEN-1:0]  ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ret_mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic [XLEN-1:0]  pc_q, pc_d, next_pc, link;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  pc_src_e          src;
  logic             taken, is_jump, ras_push, ras_pop;

  assign taken   = branch & branch_cond(btype, zero, lt, ltu);
  assign link    = pc_q + XLEN'(4);
  assign is_jump = jal | jalr;

  always_comb begin
    src     = PC_SEQ;
    next_pc = link;
    if (jalr) begin
      src     = PC_JALR;
      next_pc = jalr_target;
    end else if (jal) begin
      src     = PC_JAL;
      next_pc = pc_q + immediate;
    end else if (taken) begin
      src     = PC_BR;
      next_pc = pc_q + immediate;
    end
  end

  assign pc_d = pc_write ? next_pc : pc_q;

  // call/ret hints only count when attached to an actual jump that commits.
  assign ras_push = pc_write & is_jump & call;
  assign ras_pop  = pc_write & is_jump & ret;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign ret_mispredict = ret & (ras_empty | (ras_top != jalr_target));

  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (pc_write && ret_mispredict && !(&mis_cnt_q)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      mis_cnt_q <= '0;
    end else begin
      pc_q      <= pc_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign pc_current     = pc_q;
  assign pc_src         = src;
  assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed vector table, hand sequences for stack corner
// cases, then random traffic against a queue-based reference model.
module tb_pc_unit_ras;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, branch, zero, lt, ltu, jal, jalr, call, ret;
  logic [2:0]  btype;
  logic [31:0] immediate, jalr_target;
  logic [31:0] pc_current, ras_top;
  logic [1:0]  pc_src;
  logic        ras_empty, ras_full, ret_mispredict;
  logic [1:0]  mispredict_cnt;

  always #5 clk = ~clk;

  pc_unit_ras #(
    .XLEN(32), .RESET_PC(32'h100), .RAS_DEPTH(DEPTH), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .branch(branch), .btype(btype),
    .zero(zero), .lt(lt), .ltu(ltu), .immediate(immediate), .jal(jal), .jalr(jalr),
    .jalr_target(jalr_target), .call(call), .ret(ret), .pc_current(pc_current),
    .pc_src(pc_src), .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full),
    .ret_mispredict(ret_mispredict), .mispredict_cnt(mispredict_cnt)
  );

  typedef struct {
    logic        pw, br;
    logic [2:0]  bt;
    logic        z, l, lu;
    logic [31:0] imm;
    logic        j, jr;
    logic [31:0] tgt;
    logic        c, r;
    logic [31:0] exp_pc;
    logic [1:0]  exp_src;
    logic        exp_mis;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: the stack is a plain queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          m_cnt;
  logic [1:0]  src_seen;
  logic        mis_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pw, br, input logic [2:0] bt, input logic z, l, lu,
                              input logic [31:0] imm, input logic j, jr,
                              input logic [31:0] tgt, input logic c, r);
    vec_t v;
    v.pw = pw; v.br = br; v.bt = bt; v.z = z; v.l = l; v.lu = lu; v.imm = imm;
    v.j = j; v.jr = jr; v.tgt = tgt; v.c = c; v.r = r;
    v.exp_pc = '0; v.exp_src = '0; v.exp_mis = 1'b0;
    return v;
  endfunction

  function automatic vec_t tv(input vec_t v, input logic [31:0] epc, input logic [1:0] esrc,
                              input logic emis);
    vec_t o = v;
    o.exp_pc = epc; o.exp_src = esrc; o.exp_mis = emis;
    return o;
  endfunction

  function automatic logic m_taken(input vec_t v);
    if (!v.br) return 1'b0;
    case (v.bt)
      3'd0: return v.z;
      3'd1: return !v.z;
      3'd4: return v.l;
      3'd5: return !v.l;
      3'd6: return v.lu;
      3'd7: return !v.lu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] m_src(input vec_t v);
    if (v.jr) return 2'd3;
    if (v.j) return 2'd2;
    if (m_taken(v)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_next(input vec_t v);
    if (v.jr) return v.tgt;
    if (v.j || m_taken(v)) return m_pc + v.imm;
    return m_pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_top();
    return (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size() - 1];
  endfunction

  function automatic logic m_mis(input vec_t v);
    return v.r && ((m_ras.size() == 0) || (m_top() != v.tgt));
  endfunction

  task automatic model_reset();
    m_pc = 32'h100;
    m_ras.delete();
    m_cnt = 0;
  endtask

  task automatic apply(input vec_t v);
    pc_write = v.pw; branch = v.br; btype = v.bt; zero = v.z; lt = v.l; ltu = v.lu;
    immediate = v.imm; jal = v.j; jalr = v.jr; jalr_target = v.tgt; call = v.c; ret = v.r;
  endtask

  // One cycle: combinational outputs checked mid-cycle, state checked after the edge.
  task automatic run(input vec_t v);
    logic [31:0] nxt, link;
    logic        mis;
    apply(v);
    @(negedge clk);
    src_seen = pc_src;
    mis_seen = ret_mispredict;
    check("pc_src", pc_src, m_src(v));
    check("ret_mispredict", ret_mispredict, m_mis(v));
    check("ras_top", ras_top, m_top());
    check("ras_empty", ras_empty, m_ras.size() == 0);
    check("ras_full", ras_full, m_ras.size() == DEPTH);
    check("pc_current", pc_current, m_pc);
    check("mispredict_cnt", mispredict_cnt, m_cnt);
    nxt  = m_next(v);
    mis  = m_mis(v);
    link = m_pc + 32'd4;
    @(posedge clk);
    if (v.pw) begin
      if (mis && m_cnt < 3) m_cnt++;
      if (v.j || v.jr) begin
        if (v.c && v.r) begin
          if (m_ras.size() == 0) m_ras.push_back(link);
          else m_ras[m_ras.size() - 1] = link;
        end else if (v.c) begin
          m_ras.push_back(link);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (v.r) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
        end
      end
      m_pc = nxt;
    end
    #1;
    check("pc_after", pc_current, m_pc);
    check("ras_top_after", ras_top, m_top());
    check("cnt_after", mispredict_cnt, m_cnt);
  endtask

  vec_t tbl[11];
  vec_t idle;
  vec_t rv;
  logic [31:0] rets[5];

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(idle);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc_current, 32'h100);
    check("rst_empty", ras_empty, 1'b1);
    check("rst_full", ras_full, 1'b0);
    check("rst_top", ras_top, 32'h0);
    check("rst_cnt", mispredict_cnt, 2'd0);
    check("rst_src", pc_src, 2'd0);
    rst_n = 1'b1;

    tbl[0]  = tv(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h104, 2'd0, 0);
    tbl[1]  = tv(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h108, 2'd0, 0);
    tbl[2]  = tv(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h10C, 2'd0, 0);
    tbl[3]  = tv(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0), 32'h200, 2'd3, 0);
    tbl[4]  = tv(mk(1, 1, 3'b101, 0, 0, 0, -32'sd16, 0, 0, 0, 0, 0), 32'h1F0, 2'd1, 0);
    tbl[5]  = tv(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0), 32'h200, 2'd3, 0);
    tbl[6]  = tv(mk(1, 1, 3'b011, 0, 0, 0, -32'sd16, 0, 0, 0, 0, 0), 32'h204, 2'd0, 0);
    tbl[7]  = tv(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0), 32'h300, 2'd3, 0);
    tbl[8]  = tv(mk(1, 0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 1, 0), 32'h400, 2'd2, 0);
    tbl[9]  = tv(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h304, 0, 1), 32'h304, 2'd3, 0);
    tbl[10] = tv(mk(0, 1, 3'b000, 1, 0, 0, 32'h40, 0, 0, 0, 0, 0), 32'h304, 2'd1, 0);
    for (int i = 0; i < 11; i++) begin
      run(tbl[i]);
      check($sformatf("tbl%0d_pc", i), pc_current, tbl[i].exp_pc);
      check($sformatf("tbl%0d_src", i), src_seen, tbl[i].exp_src);
      check($sformatf("tbl%0d_mis", i), mis_seen, tbl[i].exp_mis);
    end
    check("tbl_cnt", mispredict_cnt, 2'd0);

    // Overflow: five calls into a four-entry stack, then five returns.
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0));
    for (int i = 0; i < 5; i++) run(mk(1, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0, 1, 0));
    check("ovf_full", ras_full, 1'b1);
    check("ovf_top", ras_top, 32'h54);
    rets[0] = 32'h54; rets[1] = 32'h44; rets[2] = 32'h34; rets[3] = 32'h24; rets[4] = 32'h14;
    for (int i = 0; i < 5; i++) begin
      run(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, rets[i], 0, 1));
      check($sformatf("ovf_ret%0d_mis", i), mis_seen, i == 4);
    end
    check("ovf_empty", ras_empty, 1'b1);
    check("ovf_cnt", mispredict_cnt, 2'd1);

    // Call and return together replace the top entry.
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0));
    run(mk(1, 0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 1, 0));
    run(mk(1, 0, 0, 0, 0, 0, 32'h300, 1, 0, 0, 1, 0));
    check("cr_pc", pc_current, 32'h500);
    run(mk(1, 0, 0, 0, 0, 0, 32'h8, 1, 0, 32'h204, 1, 1));
    check("cr_top", ras_top, 32'h504);
    check("cr_empty", ras_empty, 1'b0);
    check("cr_full", ras_full, 1'b0);
    run(mk(0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 0, 1, 0));
    check("stall_top", ras_top, 32'h504);
    check("stall_pc", pc_current, 32'h508);
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h504, 0, 1));
    check("cr_pop1", ras_top, 32'h104);
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h104, 0, 1));
    check("cr_pop2_empty", ras_empty, 1'b1);

    // Saturation of the two-bit counter.
    for (int i = 0; i < 5; i++) run(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hABC, 0, 1));
    check("sat_cnt", mispredict_cnt, 2'd3);

    // Random traffic against the model; counter restarted for headroom.
    rst_n = 1'b0; #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      rv = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1), 3'($urandom_range(0, 7)),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom & 32'hFFFF_FFFE, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom & 32'hFFFF_FFFE, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) && m_ras.size() > 0) rv.tgt = m_top();
      run(rv);
    end

    // Reset mid-run takes effect without waiting for a clock edge.
    run(mk(1, 0, 0, 0, 0, 0, 32'h20, 1, 0, 0, 1, 0));
    apply(idle);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc_current, 32'h100);
    check("mid_rst_empty", ras_empty, 1'b1);
    check("mid_rst_full", ras_full, 1'b0);
    check("mid_rst_top", ras_top, 32'h0);
    check("mid_rst_cnt", mispredict_cnt, 2'd0);
    check("mid_rst_src", pc_src, 2'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("post_rst_pc", pc_current, 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
# pc_unit_ras

Program-counter unit for the single-cycle/pipelined RISC-V core: holds the PC, computes the next PC from branch/jump inputs and tracks call/return addresses in a parametrised return-address stack (RAS). The RAS provides a return-target prediction and a saturating mispredict count for performance analysis. Sits at the head of the fetch path, fed by the decoder, the ALU flags and the JALR adder.

## Interface
Parameters:
- XLEN, 32, PC and address width
- RESET_PC, 0, PC value after reset
- RAS_DEPTH, 4, stack entries; power of two, ≥2
- CNT_W, 16, mispredict counter width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- pc_write  in  1  1 = commit next PC and RAS update this cycle; 0 = stall
- branch  in  1  conditional branch instruction
- btype  in  3  funct3 of branch: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; 010/011 never taken
- zero, lt, ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- immediate  in  XLEN  sign-extended byte offset for branch/jal
- jal, jalr  in  1 each  jump instructions
- jalr_target  in  XLEN  computed (rs1+imm)&~1
- call  in  1  jump writes ra (push link)
- ret  in  1  jalr with rs1=ra, rd=x0 (pop)
- pc_current  out  XLEN  registered PC
- pc_src  out  2  00 seq, 01 branch, 10 jal, 11 jalr
- ras_top  out  XLEN  predicted return address (0 when empty)
- ras_empty, ras_full  out  1 each
- ret_mispredict  out  1  combinational: ret & (ras_empty | ras_top≠jalr_target)
- mispredict_cnt  out  CNT_W  saturating count of committed mispredicted returns

## Operation
- taken = branch & condition(btype, flags); btype 010/011 → not taken.
- Priority: jalr > jal > taken branch > sequential. jalr → jalr_target; jal/branch → pc_current+immediate; else pc_current+4. All sums modulo 2^XLEN.
- pc_src reflects selected source every cycle regardless of pc_write.
- RAS: circular buffer, top pointer tp, count cnt (0..RAS_DEPTH). Link = pc_current+4.
- push only (call & ~ret): write link at tp+1, tp++, cnt = min(cnt+1, DEPTH); when full, oldest entry silently overwritten.
- pop only (ret & ~call): if cnt>0: tp--, cnt--; if empty: no change.
- call & ret together: top entry replaced with link, tp/cnt unchanged (push onto empty → cnt=1).
- call/ret ignored unless jal or jalr asserted.
- pc_write=0: PC, RAS and counter all hold; combinational outputs still valid.
- mispredict_cnt increments on committed ret_mispredict; saturates at all-ones.

## Timing
- Reset (async assert, sync-to-clk deassert by top level): pc_current=RESET_PC, tp=0, cnt=0, ras_empty=1, ras_full=0, ras_top=0, mispredict_cnt=0; pc_src=00 with inputs idle.
- pc_current updates one rising edge after pc_write=1; zero-latency next-PC path.
- RAS push/pop visible on ras_top the cycle after commit.
- Reset mid-operation discards stack contents immediately.
- ras_full = cnt==RAS_DEPTH; ras_empty = cnt==0.

## Structure
- Package pc_pkg: btype encodings, pc_src encodings (PC_SEQ, PC_BR, PC_JAL, PC_JALR).
- Sub-module ras_stack (parameters XLEN, RAS_DEPTH): push, pop, push_data, top, empty, full; owns tp/cnt/storage.
- Top holds PC register, condition decode, next-PC mux, mispredict counter.

## Test plan
- Reset with RESET_PC=0x100, then 3 cycles pc_write=1 no control → pc 0x104, 0x108, 0x10C; ras_empty=1.
- pc=0x200, branch, btype=101, lt=0, immediate=-16 → pc 0x1F0, pc_src=01; same with btype=011 → 0x204.
- jal+call at 0x300 imm 0x100, then jalr+ret jalr_target=0x304 → pc 0x400 then 0x304, ret_mispredict=0, cnt unchanged.
- DEPTH=4, 5 calls from 0x10,0x20,0x30,0x40,0x50 → full; 5 rets pop 0x54,0x44,0x34,0x24, fifth sees empty → mispredict_cnt=1.
- call & ret same cycle on link 0x504 with 2 entries → count stays 2, ras_top=0x504; pc_write=0 during a call → no push.
- Force mispredicts with CNT_W=2 five times → counter 3 and holds; assert rst_n low mid-run → all outputs reset immediately.
